clk_div_multi: RTL and testbench

- Multi-channel, runtime-programmable clock divider and tick generator. It succeeds the fixed single-output divider.
- Each of NUM_CH channels produces two outputs:
  - a divided square wave of integer period D system-clock cycles;
  - a one-cycle tick strobe, for enables in downstream logic.
- Divisors are written at run time through a simple write port and take effect glitch-free at the next period boundary.
- A global sync input phase-aligns all channels.

---
 rtl/clk_div_multi.sv | 97 +++++++++
 tb/tb_clk_div_multi.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock divider / tick generator.
// Divisor updates apply only at period boundaries, so no runt periods.
module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [CNT_W-1:0]        cfg_div,
  output logic [NUM_CH-1:0]       clk_div,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       cfg_pend,
  output logic [NUM_CH*CNT_W-1:0] cur_div
);

  logic [CNT_W-1:0] w_wval;

  // 0 and 1 are not meaningful periods; store them as 2
  assign w_wval = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act;
    logic [CNT_W-1:0] r_pdiv;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;
    logic [CNT_W-1:0] w_cnt_n;
    logic [CNT_W-1:0] w_act_n;
    logic [CNT_W-1:0] w_pdiv_n;
    logic             w_pend_n;
    logic             w_clk_n;
    logic             w_tick_n;
    logic             w_hit;
    logic             w_wrap;
    logic             w_restart;

    assign w_hit     = cfg_we && (32'(cfg_ch) == g);
    assign w_wrap    = (r_cnt == r_act - CNT_W'(1));
    assign w_restart = sync || !en[g] || w_wrap;

    // next counter / divisor state; boundaries absorb pending divisors
    always_comb begin
      w_cnt_n  = '0;
      w_act_n  = r_act;
      w_pdiv_n = r_pdiv;
      w_pend_n = r_pend;
      if (w_restart) begin
        w_pend_n = 1'b0;
        if (w_hit) begin
          w_act_n = w_wval;
        end else if (r_pend) begin
          w_act_n = r_pdiv;
        end
      end else begin
        w_cnt_n = r_cnt + CNT_W'(1);
        if (w_hit) begin
          w_pdiv_n = w_wval;
          w_pend_n = 1'b1;
        end
      end
      w_clk_n  = (w_cnt_n >= w_act_n - (w_act_n >> 1));
      w_tick_n = (w_cnt_n == w_act_n - CNT_W'(1));
    end

    // channel state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_act  <= CNT_W'(DEFAULT_DIV);
        r_pdiv <= CNT_W'(DEFAULT_DIV);
        r_pend <= 1'b0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_n;
        r_act  <= w_act_n;
        r_pdiv <= w_pdiv_n;
        r_pend <= w_pend_n;
        r_clk  <= w_clk_n;
        r_tick <= w_tick_n;
      end
    end

    assign clk_div[g]                = r_clk;
    assign tick[g]                   = r_tick;
    assign cfg_pend[g]               = r_pend;
    assign cur_div[g*CNT_W +: CNT_W] = r_act;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scoreboard bench for clk_div_multi.
// Driver pushes model expectations; monitor pops and compares.
module tb_clk_div_multi;

  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int DEF = 2;

  typedef struct {
    logic [NCH-1:0]    clk;
    logic [NCH-1:0]    tck;
    logic [NCH-1:0]    pnd;
    logic [NCH*CW-1:0] cur;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    en;
  logic              sync;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CW-1:0]     cfg_div;
  logic [NCH-1:0]    clk_div;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    cfg_pend;
  logic [NCH*CW-1:0] cur_div;

  clk_div_multi #(
    .NUM_CH(NCH),
    .CNT_W(CW),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .sync(sync),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .clk_div(clk_div),
    .tick(tick),
    .cfg_pend(cfg_pend),
    .cur_div(cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;

  // reference model: position within current period, period length,
  // and an optional divisor queued for the next period start
  int m_pos[NCH];
  int m_per[NCH];
  int m_has[NCH];
  int m_nxt[NCH];

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pos[i] = 0;
      m_per[i] = DEF;
      m_has[i] = 0;
      m_nxt[i] = DEF;
    end
  endtask

  task automatic m_edge(input logic [NCH-1:0] e, input logic s,
                        input logic we, input int ch, input int v);
    int val;
    bit hit;
    bit new_period;
    val = (v < 2) ? 2 : v;
    for (int i = 0; i < NCH; i++) begin
      hit = we && (ch == i);
      new_period = s || !e[i] || (m_pos[i] + 1 == m_per[i]);
      if (new_period) begin
        if (hit) m_per[i] = val;
        else if (m_has[i] != 0) m_per[i] = m_nxt[i];
        m_has[i] = 0;
        m_pos[i] = 0;
      end else begin
        m_pos[i] = m_pos[i] + 1;
        if (hit) begin
          m_nxt[i] = val;
          m_has[i] = 1;
        end
      end
    end
  endtask

  function automatic exp_t m_out();
    exp_t x;
    for (int i = 0; i < NCH; i++) begin
      x.clk[i] = (m_pos[i] >= m_per[i] - m_per[i] / 2);
      x.tck[i] = (m_pos[i] == m_per[i] - 1);
      x.pnd[i] = (m_has[i] != 0);
      x.cur[i*CW +: CW] = CW'(m_per[i]);
    end
    return x;
  endfunction

  task automatic chk(input string nm, input logic [NCH*CW-1:0] act,
                     input logic [NCH*CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // one clock of stimulus; expectation is queued for the next observation
  task automatic step(input logic r, input logic [NCH-1:0] e,
                      input logic s, input logic we,
                      input logic [1:0] ch, input logic [CW-1:0] v);
    @(negedge clk);
    rst_n   = r;
    en      = e;
    sync    = s;
    cfg_we  = we;
    cfg_ch  = ch;
    cfg_div = v;
    if (!r) m_reset();
    else m_edge(e, s, we, int'(ch), int'(v));
    q.push_back(m_out());
  endtask

  // reset asserted between clock edges; effect must be immediate
  task automatic async_rst();
    @(negedge clk);
    #2;
    m_reset();
    q.push_back(m_out());
    rst_n = 1'b0;
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] e);
    for (int k = 0; k < n; k++) step(1'b1, e, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  // monitor: outputs are valid after every edge, including async reset
  initial begin
    exp_t x;
    while (!done) begin
      @(posedge clk or negedge rst_n);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("clk_div",  {{(NCH*CW-NCH){1'b0}}, clk_div},  {{(NCH*CW-NCH){1'b0}}, x.clk});
        chk("tick",     {{(NCH*CW-NCH){1'b0}}, tick},     {{(NCH*CW-NCH){1'b0}}, x.tck});
        chk("cfg_pend", {{(NCH*CW-NCH){1'b0}}, cfg_pend}, {{(NCH*CW-NCH){1'b0}}, x.pnd});
        chk("cur_div",  cur_div, x.cur);
      end
    end
  end

  initial begin
    logic [NCH-1:0] e;
    logic           s;
    logic           we;
    logic [1:0]     ch;
    logic [CW-1:0]  v;
    int             sel;
    bit             rst_done;
    rst_n   = 1'b0;
    en      = '0;
    sync    = 1'b0;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    m_reset();
    step(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
    step(1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
    // default divisor of 2 on all channels
    idle(6, 3'b111);
    // disabled write of 5 on ch0, then enable
    step(1'b1, 3'b110, 1'b0, 1'b1, 2'd0, 8'd5);
    idle(12, 3'b111);
    // ch1 at D=4, write 10 one cycle into the period
    step(1'b1, 3'b101, 1'b0, 1'b1, 2'd1, 8'd4);
    step(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
    step(1'b1, 3'b111, 1'b0, 1'b1, 2'd1, 8'd10);
    idle(24, 3'b111);
    // clamped writes and an out-of-range channel
    step(1'b1, 3'b011, 1'b0, 1'b1, 2'd2, 8'd9);
    step(1'b1, 3'b011, 1'b0, 1'b1, 2'd2, 8'd0);
    step(1'b1, 3'b011, 1'b0, 1'b1, 2'd2, 8'd1);
    step(1'b1, 3'b011, 1'b0, 1'b1, 2'd3, 8'd7);
    idle(3, 3'b111);
    // D=3 and D=6 brought into phase by sync
    step(1'b1, 3'b110, 1'b0, 1'b1, 2'd0, 8'd3);
    step(1'b1, 3'b101, 1'b0, 1'b1, 2'd1, 8'd6);
    idle(int'($urandom_range(1, 7)), 3'b111);
    step(1'b1, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0);
    idle(14, 3'b111);
    // sync held high, then released
    step(1'b1, 3'b111, 1'b1, 1'b1, 2'd2, 8'd4);
    step(1'b1, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0);
    idle(8, 3'b111);
    // maximum divisor
    step(1'b1, 3'b011, 1'b0, 1'b1, 2'd2, 8'd255);
    idle(260, 3'b111);
    // randomized traffic with one async reset while a write is pending
    rst_done = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!rst_done && k > 1500 && m_has[0] + m_has[1] + m_has[2] > 0) begin
        async_rst();
        step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
        step(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
        rst_done = 1;
      end else begin
        for (int i = 0; i < NCH; i++) e[i] = ($urandom_range(0, 15) != 0);
        s   = ($urandom_range(0, 39) == 0);
        we  = ($urandom_range(0, 5) == 0);
        ch  = 2'($urandom_range(0, 3));
        sel = int'($urandom_range(0, 19));
        if (sel == 0) v = 8'd0;
        else if (sel == 1) v = 8'd1;
        else if (sel == 2) v = 8'd255;
        else v = 8'($urandom_range(2, 12));
        step(1'b1, e, s, we, ch, v);
      end
    end
    if (!rst_done) begin
      async_rst();
      step(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
    end
    @(negedge clk);
    @(negedge clk);
    done = 1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
